mem_access_arbiter: RTL

Shares the single synchronous test memory between the CPU's instruction-fetch unit (port I, read-only, 16-bit) and load/store unit (port D, 8/16-bit read/write). Each transaction is a request/data_ready handshake on the memory side and a hold-until-ack handshake on the requester side. Requests from I and D are arbitrated round-robin. A per-transaction timeout ensures a stuck memory never hangs the core.

---
 rtl/pkg_cpu.sv | 21 ++
 rtl/mem_arbiter_rr_pick.sv | 23 ++
 rtl/mem_access_arbiter.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/pkg_cpu.sv
// Shared CPU-side definitions: address width, access sizes, and the
// memory arbiter's state and port-select encodings.
`ifndef CPU_ADDR_WIDTH
`define CPU_ADDR_WIDTH 16
`endif

package pkg_cpu;

   localparam logic cpu_data_acc_sz_8  = 1'b0;
   localparam logic cpu_data_acc_sz_16 = 1'b1;

   localparam logic ARB_PORT_I = 1'b0;
   localparam logic ARB_PORT_D = 1'b1;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_BUSY,
      ARB_RECOVER
   } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Two-way round-robin picker: with both ports requesting, the port that
// was not granted last wins; a lone requester always wins.
module mem_arbiter_rr_pick
   import pkg_cpu::*;
(
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic grant,
   output logic grant_valid
);

   always_comb begin
      grant       = ARB_PORT_D;
      grant_valid = req_i | req_d;
      if (req_i && req_d) begin
         grant = (last_grant == ARB_PORT_D) ? ARB_PORT_I : ARB_PORT_D;
      end else if (req_i) begin
         grant = ARB_PORT_I;
      end
   end

endmodule

// File: rtl/mem_access_arbiter.sv
// Shares the single test memory between the fetch (I) and load/store (D)
// ports, with a per-transaction timeout so a stuck memory cannot hang the core.
module mem_access_arbiter
   import pkg_cpu::*;
#(
   parameter int TIMEOUT_CYCLES = 15
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       i_req,
   input  logic [`CPU_ADDR_WIDTH-1:0] i_addr,
   output logic                       i_ack,
   output logic                       i_err,
   output logic [15:0]                i_rdata,
   input  logic                       d_req,
   input  logic                       d_we,
   input  logic                       d_sz,
   input  logic [`CPU_ADDR_WIDTH-1:0] d_addr,
   input  logic [15:0]                d_wdata,
   output logic                       d_ack,
   output logic                       d_err,
   output logic [15:0]                d_rdata,
   output logic                       mem_req_rdwr,
   output logic [`CPU_ADDR_WIDTH-1:0] mem_addr,
   output logic                       mem_data_acc_sz,
   output logic [7:0]                 mem_wdata_8,
   output logic [15:0]                mem_wdata_16,
   output logic                       mem_we_8,
   output logic                       mem_we_16,
   input  logic [7:0]                 mem_rdata_8,
   input  logic [15:0]                mem_rdata_16,
   input  logic                       mem_data_ready
);

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

   arb_state_t state, state_next;
   logic       last_grant;
   logic       grantee;
   logic [CNT_W-1:0] tmo_cnt;
   logic       pick_grant;
   logic       pick_valid;
   logic       do_grant;
   logic       do_done;
   logic       do_timeout;
   logic [15:0] rdata_cap;

   mem_arbiter_rr_pick u_rr_pick (
      .req_i       (i_req),
      .req_d       (d_req),
      .last_grant  (last_grant),
      .grant       (pick_grant),
      .grant_valid (pick_valid)
   );

   assign rdata_cap = (mem_data_acc_sz == cpu_data_acc_sz_16) ? mem_rdata_16
                                                              : {8'h00, mem_rdata_8};

   // A data_ready arriving on the expiry cycle still counts as a completion.
   always_comb begin
      state_next = state;
      do_grant   = 1'b0;
      do_done    = 1'b0;
      do_timeout = 1'b0;
      unique case (state)
         ARB_IDLE: begin
            if (pick_valid) begin
               do_grant   = 1'b1;
               state_next = ARB_BUSY;
            end
         end
         ARB_BUSY: begin
            if (mem_data_ready) begin
               do_done    = 1'b1;
               state_next = ARB_RECOVER;
            end else if (tmo_cnt == CNT_MAX) begin
               do_timeout = 1'b1;
               state_next = ARB_RECOVER;
            end
         end
         ARB_RECOVER: begin
            if (!mem_data_ready) begin
               state_next = ARB_IDLE;
            end
         end
         default: state_next = ARB_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Memory-side request registers, timeout counter and per-port capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant      <= ARB_PORT_I;
         grantee         <= ARB_PORT_I;
         tmo_cnt         <= '0;
         mem_req_rdwr    <= 1'b0;
         mem_addr        <= '0;
         mem_data_acc_sz <= 1'b0;
         mem_wdata_8     <= '0;
         mem_wdata_16    <= '0;
         mem_we_8        <= 1'b0;
         mem_we_16       <= 1'b0;
         i_ack           <= 1'b0;
         i_err           <= 1'b0;
         i_rdata         <= '0;
         d_ack           <= 1'b0;
         d_err           <= 1'b0;
         d_rdata         <= '0;
      end else begin
         i_ack <= 1'b0;
         i_err <= 1'b0;
         d_ack <= 1'b0;
         d_err <= 1'b0;

         if (do_grant) begin
            grantee      <= pick_grant;
            last_grant   <= pick_grant;
            tmo_cnt      <= '0;
            mem_req_rdwr <= 1'b1;
            if (pick_grant == ARB_PORT_I) begin
               mem_addr        <= i_addr;
               mem_data_acc_sz <= cpu_data_acc_sz_16;
               mem_wdata_8     <= '0;
               mem_wdata_16    <= '0;
               mem_we_8        <= 1'b0;
               mem_we_16       <= 1'b0;
            end else begin
               mem_addr        <= d_addr;
               mem_data_acc_sz <= d_sz;
               mem_wdata_8     <= d_wdata[7:0];
               mem_wdata_16    <= d_wdata;
               mem_we_8        <= d_we & (d_sz == cpu_data_acc_sz_8);
               mem_we_16       <= d_we & (d_sz == cpu_data_acc_sz_16);
            end
         end

         if (state == ARB_BUSY && !do_done && !do_timeout) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end

         if (do_done || do_timeout) begin
            mem_req_rdwr <= 1'b0;
            mem_we_8     <= 1'b0;
            mem_we_16    <= 1'b0;
            if (grantee == ARB_PORT_I) begin
               i_ack <= 1'b1;
               i_err <= do_timeout;
               if (do_done) begin
                  i_rdata <= rdata_cap;
               end
            end else begin
               d_ack <= 1'b1;
               d_err <= do_timeout;
               if (do_done) begin
                  d_rdata <= rdata_cap;
               end
            end
         end
      end
   end

endmodule
